subbytes_shiftrows: RTL and testbench
=====================================

SUBBYTES_SHIFTROWS -- requirements
Module: subbytes_shiftrows

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start_i, input, 1 bit: request to process data_i; sampled only in IDLE.
REQ-004 SHALL have port decrypt_i, input, 1 bit: 0 selects forward S-box and ShiftRows, 1 selects inverse; sampled with start_i and held for the whole operation.
REQ-005 SHALL have port data_i, input, 128 bits: AES state, column-major; byte i is bits [127-8i : 120-8i].
REQ-006 SHALL have port ready_o, output, 1 bit: one-cycle pulse marking data_o as newly valid.
REQ-007 SHALL have port data_o, output, 128 bits: transformed state, held until the next completion.

Function
REQ-008 SHALL implement FSM states IDLE and SUB.
REQ-009 In IDLE with start_i=1 at an edge, SHALL capture data_i and decrypt_i, clear the byte counter (4 bits), and enter SUB.
REQ-010 In SUB, SHALL present captured byte[counter] to the S-box each cycle, write the S-box result into result byte[counter] at the edge, and increment the counter.
REQ-011 At the edge where counter=15, SHALL write the final byte, load data_o from the completed (optionally shifted) result, assert ready_o, and return to IDLE.
REQ-012 Latency: start_i sampled at edge E0 SHALL give ready_o=1 registered at edge E16, deasserting at E17.
REQ-013 SHALL ignore start_i while in SUB, so data_i and decrypt_i changes mid-operation have no effect.
REQ-014 SHALL accept start_i at E17 at the earliest; start_i high at E16 (the completing edge) is not accepted.
REQ-015 ready_o SHALL be high for exactly one cycle per operation; data_o SHALL change only on completion or reset.
REQ-016 Byte substitution SHALL be the FIPS-197 S-box (decrypt_i=0) or inverse S-box (decrypt_i=1), combinational, one byte per cycle.
REQ-017 Counter SHALL wrap from 15 to 0 on leaving SUB; no other wrap occurs.

Reset
REQ-018 On reset low, SHALL asynchronously force: state IDLE, counter 0, ready_o 0, data_o 0, and the capture and result registers 0.
REQ-019 Reset asserted mid-operation SHALL abandon the operation with no ready_o pulse; the first start_i after reset release starts a fresh operation.

Configuration
REQ-020 With macro SHIFTROWS_EN defined, data_o SHALL apply ShiftRows after substitution. Row r=i mod 4, column c=i/4. Forward: out[r][c]=sub[r][(c+r) mod 4]. Inverse: out[r][c]=sub[r][(c-r) mod 4].
REQ-021 Without SHIFTROWS_EN, data_o SHALL equal the substituted bytes in their original positions, with identical latency.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (IDLE=0, SUB=1), the byte count constant 16 and the state width 128.
REQ-023 The S-box SHALL be a sub-module named sbox: 8-bit input, decrypt select, 8-bit output, purely combinational, reusable by key expansion.

Verification
REQ-024 All-zero data_i, decrypt_i=0, start at E0 -> ready_o high after E16 only, and data_o = 0x63 repeated 16 times.
REQ-025 data_i=193de3bea0f4e22b9ac68d2ae9f84808, decrypt_i=0 -> with SHIFTROWS_EN: d4bf5d30e0b452aeb84111f11e2798e5; without: d42711aee0bf98f1b8b45de51e415230.
REQ-026 decrypt_i=1 with data_i=d4bf5d30e0b452aeb84111f11e2798e5 and SHIFTROWS_EN -> data_o=193de3bea0f4e22b9ac68d2ae9f84808.
REQ-027 start_i held high continuously -> ready_o pulses on E16, E33, E50; data_i changes during SUB are not reflected.
REQ-028 reset low at E8 of an operation -> ready_o and data_o are 0 at once, no pulse at E16, and a later start completes after 16 edges.

Source files
------------

// File: rtl/subbytes_shiftrows_pkg.sv
// Shared definitions for the SubBytes/ShiftRows engine: FSM encoding, sizes and
// the ShiftRows byte permutation used when SHIFTROWS_EN is defined.
package subbytes_shiftrows_pkg;

  localparam int unsigned NumBytes = 16;
  localparam int unsigned StateW   = 128;

  typedef enum logic {
    StIdle = 1'b0,
    StSub  = 1'b1
  } state_e;

  // Byte 0 occupies the most significant byte, matching the column-major bus layout.
  typedef logic [0:NumBytes-1][7:0] aes_state_t;

  // Byte i sits at row i[1:0], column i[3:2]; 2-bit column arithmetic wraps mod 4.
  function automatic aes_state_t shift_rows(aes_state_t s, logic inv);
    aes_state_t o;
    logic [3:0] idx;
    logic [1:0] r, c, src_c;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      idx   = 4'(i);
      r     = idx[1:0];
      c     = idx[3:2];
      src_c = inv ? (c - r) : (c + r);
      o[idx] = s[{src_c, r}];
    end
    return o;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES S-box / inverse S-box, purely combinational, computed as GF(2^8)
// inversion plus the FIPS-197 affine map so no 256-entry tables are needed.
module sbox (
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] x, r;
    x = gf_mul(a, a);
    r = x;
    for (int k = 0; k < 6; k++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // Select forward or inverse substitution.
  always_comb begin
    if (inv_i) out_o = gf_inv(inv_affine(in_i));
    else       out_o = affine(gf_inv(in_i));
  end

endmodule

// File: rtl/subbytes_shiftrows.sv
// Byte-serial AES SubBytes (and optionally ShiftRows) engine: one S-box,
// one byte per cycle, result published with a one-cycle ready_o pulse.
// Define SHIFTROWS_EN to apply (inverse) ShiftRows to the published result.
module subbytes_shiftrows
  import subbytes_shiftrows_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              decrypt_i,
  input  logic [StateW-1:0] data_i,
  output logic              ready_o,
  output logic [StateW-1:0] data_o
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dec_q, dec_d;
  logic       ready_q, ready_d;
  aes_state_t din_q, din_d;
  aes_state_t res_q, res_d;
  aes_state_t dout_q, dout_d;
  logic [7:0] sub_byte;

  sbox u_sbox (
    .in_i  (din_q[cnt_q]),
    .inv_i (dec_q),
    .out_o (sub_byte)
  );

  // Next-state: capture on start, substitute one byte per cycle, publish on the last byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    din_d   = din_q;
    res_d   = res_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          din_d   = data_i;
          dec_d   = decrypt_i;
          cnt_d   = 4'd0;
          state_d = StSub;
        end
      end
      StSub: begin
        res_d[cnt_q] = sub_byte;
        cnt_d        = cnt_q + 4'd1;  // 15 -> 0 wrap on the completing edge
        if (cnt_q == 4'(NumBytes - 1)) begin
          state_d = StIdle;
          ready_d = 1'b1;
`ifdef SHIFTROWS_EN
          dout_d  = shift_rows(res_d, dec_q);
`else
          dout_d  = res_d;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      dec_q   <= 1'b0;
      ready_q <= 1'b0;
      din_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      ready_q <= ready_d;
      din_q   <= din_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = dout_q;

endmodule

// File: tb/tb_subbytes_shiftrows.sv
// Self-checking bench for subbytes_shiftrows: known-answer table, randomized
// operations against a table-built reference model, and multi-cycle corner cases.
module tb_subbytes_shiftrows;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic         decrypt_i;
  logic [127:0] data_i;
  logic         ready_o;
  logic [127:0] data_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  typedef struct {
    logic [127:0] data;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  subbytes_shiftrows dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .decrypt_i (decrypt_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .data_o    (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Inverse by exhaustive search, affine map bit by bit, inverse S-box by table inversion.
  task automatic build_tables();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
               ^ inv[(i + 7) % 8] ^ cst[i];
      sb[a] = s;
    end
    for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
  endtask

  function automatic logic [127:0] ref_model(logic [127:0] d, logic dec);
    logic [7:0]   s [16];
    logic [127:0] o;
    int           r, c, src;
    for (int i = 0; i < 16; i++)
      s[i] = dec ? isb[d[127-8*i -: 8]] : sb[d[127-8*i -: 8]];
    o = '0;
    for (int i = 0; i < 16; i++) begin
      r = i % 4;
      c = i / 4;
`ifdef SHIFTROWS_EN
      src = dec ? (c - r + 4) % 4 : (c + r) % 4;
`else
      src = c;
`endif
      o[127-8*i -: 8] = s[r + 4 * src];
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation; inputs scrambled during SUB. Returns ready latency, output, and
  // the number of cycles data_o moved before completion.
  task automatic run_op(input logic [127:0] d, input logic dec, output int lat,
                        output logic [127:0] dout, output int early);
    logic [127:0] prev;
    prev  = data_o;
    early = 0;
    lat   = -1;
    @(negedge clk);
    data_i    = d;
    decrypt_i = dec;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      data_i    = rand128();
      decrypt_i = 1'($urandom);
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        break;
      end
      if (data_o !== prev) early++;
    end
    dout = data_o;
  endtask

  task automatic op_and_check(input string name, input logic [127:0] d, input logic dec,
                              input logic [127:0] exp);
    int           lat, early;
    logic [127:0] dout;
    run_op(d, dec, lat, dout, early);
    check_int({name, "_latency"}, lat, 16);
    check_val({name, "_data"}, dout, exp);
    check_int({name, "_early_change"}, early, 0);
    @(posedge clk);
    #1;
    check_val({name, "_ready_fall"}, 128'(ready_o), 128'(0));
    check_val({name, "_hold"}, data_o, exp);
  endtask

  task automatic count_pulses(input int n_edges, output int pulses);
    pulses = 0;
    for (int k = 0; k < n_edges; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) pulses++;
    end
  endtask

  initial begin
    logic [127:0] hist_d [0:53];
    logic         hist_dec [0:53];
    int           pulse_at [$];
    int           pulses;
    logic [127:0] d, expv;
    logic         dec;

    vecs[0] = '{128'h0, 1'b0, {16{8'h63}}};
    vecs[1] = '{128'h0, 1'b1, {16{8'h52}}};
    vecs[2] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
`ifdef SHIFTROWS_EN
    vecs[3] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[4] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
                128'h193de3bea0f4e22b9ac68d2ae9f84808};
`else
    vecs[3] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[4] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                128'h193de3bea0f4e22b9ac68d2ae9f84808};
`endif

    build_tables();

    reset     = 1'b0;
    start_i   = 1'b0;
    decrypt_i = 1'b0;
    data_i    = '0;
    #3;
    check_val("reset_ready", 128'(ready_o), 128'(0));
    check_val("reset_data", data_o, 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Known-answer table.
    for (int i = 0; i < 5; i++)
      op_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].dec, vecs[i].exp);

    // Randomized operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      d   = rand128();
      dec = 1'($urandom);
      op_and_check($sformatf("rand%0d", i), d, dec, ref_model(d, dec));
    end

    // start_i high only on the completing edge must not launch a new operation.
    @(negedge clk);
    data_i    = rand128();
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check_val("e16_ready", 128'(ready_o), 128'(1));
    count_pulses(22, pulses);
    check_int("e16_start_ignored", pulses, 0);

    // start_i held high: pulses at E16, E33, E50 with inputs changing every cycle.
    @(negedge clk);
    hist_d[0]   = rand128();
    hist_dec[0] = 1'($urandom);
    data_i      = hist_d[0];
    decrypt_i   = hist_dec[0];
    start_i     = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      @(posedge clk);
      #1;
      if (k > 0 && ready_o) begin
        pulse_at.push_back(k);
        if (k >= 16) begin
          expv = ref_model(hist_d[k-16], hist_dec[k-16]);
          check_val($sformatf("cont_data_e%0d", k), data_o, expv);
        end
      end
      @(negedge clk);
      hist_d[k+1]   = rand128();
      hist_dec[k+1] = 1'($urandom);
      data_i        = hist_d[k+1];
      decrypt_i     = hist_dec[k+1];
    end
    start_i = 1'b0;
    check_int("cont_pulse_count", pulse_at.size(), 3);
    check_int("cont_pulse0", pulse_at.size() > 0 ? pulse_at[0] : -1, 16);
    check_int("cont_pulse1", pulse_at.size() > 1 ? pulse_at[1] : -1, 33);
    check_int("cont_pulse2", pulse_at.size() > 2 ? pulse_at[2] : -1, 50);
    repeat (20) @(posedge clk);

    // Reset at E8 abandons the operation; a later start runs a fresh one.
    d = rand128();
    op_and_check("pre_reset", d, 1'b0, ref_model(d, 1'b0));
    @(negedge clk);
    data_i  = rand128();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_mid_ready", 128'(ready_o), 128'(0));
    check_val("rst_mid_data", data_o, 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_pulses(20, pulses);
    check_int("rst_no_pulse", pulses, 0);
    check_val("rst_data_stays_zero", data_o, 128'(0));
    d = rand128();
    op_and_check("post_reset", d, 1'b1, ref_model(d, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
